// File: rtl/count_seq_pkg.sv
// count_seq_pkg
//   Shared definitions for the count_seq sequencer and its counter core:
//   default counter width and the sequencer state enumeration.
package count_seq_pkg;

  localparam int unsigned COUNT_SEQ_WIDTH = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cnt_core.sv
// cnt_core
//   WIDTH-bit counter register with synchronous controls.
//   Ports:
//     clk      - clock, rising edge
//     clr      - synchronous clear to zero (highest priority)
//     ld_zero  - synchronous load of zero (used for continuous-mode wrap)
//     en       - increment by one when neither clr nor ld_zero is set
//     q        - registered count
module cnt_core
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld_zero,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || ld_zero) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/count_seq.sv
// count_seq
//   Run-controlled counter sequencer. A start accepted in IDLE latches the
//   terminal count (len) and mode (cont); the count then runs 0..len_r,
//   either finishing with a one-cycle done pulse or, in continuous mode,
//   wrapping back to 0 with a one-cycle wrap pulse. pause freezes the count,
//   abort cancels the run, rst returns everything to IDLE.
//   Ports:
//     clk   - clock, rising edge
//     rst   - synchronous active-high reset
//     start - run request, only honoured in IDLE
//     len   - terminal count, latched on accepted start
//     cont  - continuous mode, latched on accepted start
//     pause - level, freezes the count while high
//     abort - level, cancels an active run
//     q     - registered current count
//     busy  - high while in RUN or HOLD
//     done  - one-cycle pulse when a non-continuous run completes
//     wrap  - one-cycle pulse when q returns to 0 in continuous mode
module count_seq
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] len,
  input  logic             cont,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             cont_q, cont_d;
  logic             wrap_q, wrap_d;

  logic             cnt_clr;
  logic             cnt_ld_zero;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_val;
  logic             at_term;

  cnt_core #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk     (clk),
    .clr     (cnt_clr),
    .ld_zero (cnt_ld_zero),
    .en      (cnt_en),
    .q       (cnt_val)
  );

  assign at_term = (cnt_val == len_q);

  // HOLD with pause released is evaluated exactly like RUN, so counting
  // restarts on the release edge and a pause of N cycles delays completion
  // by exactly N cycles.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cont_d      = cont_q;
    wrap_d      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_ld_zero = 1'b0;
    cnt_en      = 1'b0;

    if (rst) begin
      state_d = S_IDLE;
      len_d   = '0;
      cont_d  = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_clr = 1'b1;
          if (start) begin
            len_d   = len;
            cont_d  = cont;
            state_d = S_RUN;
          end
        end
        S_RUN, S_HOLD: begin
          if (abort) begin
            state_d = S_IDLE;
            cnt_clr = 1'b1;
          end else if (pause) begin
            state_d = S_HOLD;
          end else if (at_term) begin
            if (cont_q) begin
              state_d     = S_RUN;
              cnt_ld_zero = 1'b1;
              wrap_d      = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            state_d = S_RUN;
            cnt_en  = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    len_q   <= len_d;
    cont_q  <= cont_d;
    wrap_q  <= wrap_d;
  end

  assign q    = cnt_val;
  assign busy = (state_q == S_RUN) || (state_q == S_HOLD);
  assign done = (state_q == S_DONE);
  assign wrap = wrap_q;

endmodule

// File: tb/tb_count_seq.sv
// tb_count_seq
//   Directed scenarios followed by random stimulus; every cycle the DUT
//   outputs are compared against a behavioural run model of the sequencer.
module tb_count_seq;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst, start, cont, pause, abort;
  logic [W-1:0] len;
  logic [W-1:0] q;
  logic         busy, done, wrap;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: a run is either active (counting/holding), finishing
  // (the single done cycle) or absent.
  bit m_active, m_finish, m_wrap, m_cont;
  int m_q, m_len;

  always #5 clk = ~clk;

  count_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len   (len),
    .cont  (cont),
    .pause (pause),
    .abort (abort),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_active = 0; m_finish = 0; m_wrap = 0; m_q = 0; m_len = 0; m_cont = 0;
    end else if (m_finish) begin
      m_finish = 0; m_wrap = 0; m_q = 0;
    end else if (!m_active) begin
      m_wrap = 0;
      if (start) begin
        m_active = 1; m_len = int'(len); m_cont = cont; m_q = 0;
      end
    end else begin
      m_wrap = 0;
      if (abort) begin
        m_active = 0; m_q = 0;
      end else if (pause) begin
        // count frozen
      end else if (m_q == m_len) begin
        if (m_cont) begin
          m_q = 0; m_wrap = 1;
        end else begin
          m_active = 0; m_finish = 1;
        end
      end else begin
        m_q = m_q + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_q", 32'(q), 32'(m_q));
    chk("model_busy", 32'(busy), 32'(m_active));
    chk("model_done", 32'(done), 32'(m_finish));
    chk("model_wrap", 32'(wrap), 32'(m_wrap));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1; start = 0; len = '0; cont = 0; pause = 0; abort = 0;
    tick(); tick();
    chk("reset_q", 32'(q), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 0;

    // abort in IDLE has no effect; start together with rst is ignored
    abort = 1; tick(); chk("idle_abort_busy", 32'(busy), 0); abort = 0;
    rst = 1; start = 1; len = 3; tick();
    rst = 0; start = 0; tick();
    chk("rst_start_busy", 32'(busy), 0);

    // len=3 single run
    start = 1; len = 3; cont = 0; tick(); start = 0;
    chk("r030_q0", 32'(q), 0);
    chk("r030_busy", 32'(busy), 1);
    for (int k = 1; k <= 3; k++) begin
      tick(); chk("r030_qk", 32'(q), 32'(k));
    end
    tick();
    chk("r030_done", 32'(done), 1);
    chk("r030_done_q", 32'(q), 3);
    chk("r030_done_busy", 32'(busy), 0);
    tick();
    chk("r030_idle_q", 32'(q), 0);
    chk("r030_idle_done", 32'(done), 0);

    // continuous len=2 then abort
    start = 1; len = 2; cont = 1; tick(); start = 0; cont = 0;
    chk("r031_q0", 32'(q), 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("r031_q", 32'(q), 32'(i % 3));
      chk("r031_wrap", 32'(wrap), (i == 3) ? 1 : 0);
      chk("r031_nodone", 32'(done), 0);
    end
    abort = 1; tick(); abort = 0;
    chk("r031_abort_q", 32'(q), 0);
    chk("r031_abort_busy", 32'(busy), 0);

    // len=5 with 3 paused cycles at q=2
    start = 1; len = 5; tick(); start = 0;
    tick(); tick();
    chk("r032_q2", 32'(q), 2);
    pause = 1;
    repeat (3) begin
      tick(); chk("r032_hold_q", 32'(q), 2); chk("r032_hold_busy", 32'(busy), 1);
    end
    pause = 0;
    n = 6;
    while (!done && n < 40) begin
      tick(); n++;
    end
    chk("r032_done_cycle", 32'(n), 10);
    tick();

    // rst mid-run, then a normal len=1 run
    start = 1; len = 7; tick(); start = 0;
    repeat (4) tick();
    chk("r033_q4", 32'(q), 4);
    rst = 1; tick(); rst = 0;
    chk("r033_rst_q", 32'(q), 0);
    chk("r033_rst_busy", 32'(busy), 0);
    chk("r033_rst_done", 32'(done), 0);
    start = 1; len = 1; tick(); start = 0;
    chk("r033_q0", 32'(q), 0);
    tick(); chk("r033_q1", 32'(q), 1);
    tick(); chk("r033_done", 32'(done), 1);
    tick();

    // len=0 single run; start during DONE ignored
    start = 1; len = 0; tick(); start = 0;
    chk("r034_q0", 32'(q), 0);
    chk("r034_busy", 32'(busy), 1);
    tick(); chk("r034_done", 32'(done), 1);
    start = 1; len = 5; tick(); start = 0;
    chk("r034_ign_busy", 32'(busy), 0);
    tick(); chk("r034_ign_busy2", 32'(busy), 0);

    // abort beats pause; len change mid-run has no effect
    start = 1; len = 5; tick(); start = 0;
    repeat (3) tick();
    chk("r035_q3", 32'(q), 3);
    abort = 1; pause = 1; tick(); abort = 0; pause = 0;
    chk("r035_abort_q", 32'(q), 0);
    chk("r035_abort_busy", 32'(busy), 0);
    start = 1; len = 4; tick(); start = 0; len = 6;
    n = 0;
    while (!done && n < 20) begin
      tick(); n++;
    end
    chk("r035_done_seen", 32'(done), 1);
    chk("r035_done_q", 32'(q), 4);
    tick();

    // len=0 continuous: q stays 0 with a wrap each cycle
    start = 1; len = 0; cont = 1; tick(); start = 0; cont = 0;
    repeat (3) begin
      tick(); chk("r022_wrap", 32'(wrap), 1); chk("r022_q", 32'(q), 0);
    end
    abort = 1; tick(); abort = 0;

    // random phase
    repeat (500) begin
      rst   = ($urandom_range(0, 99) < 2);
      abort = ($urandom_range(0, 99) < 4);
      pause = ($urandom_range(0, 99) < 20);
      start = ($urandom_range(0, 99) < 40);
      len   = W'($urandom_range(0, 7));
      cont  = 1'($urandom_range(0, 1));
      tick();
      chk("rand_q_le_len", 32'(int'(q) <= m_len), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
